fxu_rs: RTL and testbench

Reservation-station array feeding the fixed-point unit (`fxu`) in the Tomasulo core. It accepts issued ADD/JEQ instructions, holds each until both operands are available, and snoops the common data bus (CDB) to capture operand values. It dispatches ready entries to `fxu` using a fixed every-other-cycle cadence matched to the FXU's two-state pipeline. Each entry's tag stays allocated until its own result appears on the CDB, so every tag stays unique while in flight.

---
 rtl/tomasulo_pkg.sv | 18 +
 rtl/fxu_rs_entry.sv | 102 ++++++++++
 rtl/fxu_rs.sv | 133 +++++++++++++
 tb/tb_fxu_rs.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: opcodes, tag/data widths and
// the reservation-station entry states.
package tomasulo_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_JEQ = 4'd6;

    typedef enum logic [1:0] {
        RS_FREE,
        RS_WAITING,
        RS_READY,
        RS_EXEC
    } rs_state_e;

endpackage

// File: rtl/fxu_rs_entry.sv
// One reservation-station entry: state machine, operand registers and
// CDB snooping, including the issue-cycle bypass.
module fxu_rs_entry
    import tomasulo_pkg::*;
#(
    parameter logic [TAG_W-1:0] TAG = 6'h08
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_i,
    input  logic [3:0]        op_i,
    input  logic              rdy0_i,
    input  logic              rdy1_i,
    input  logic [DATA_W-1:0] src0_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic              dispatch_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              free_o,
    output logic              ready_o,
    output logic [3:0]        op_o,
    output logic [DATA_W-1:0] val0_o,
    output logic [DATA_W-1:0] val1_o
);

    rs_state_e         state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] v0_q, v0_d, v1_q, v1_d;
    logic              r0_q, r0_d, r1_q, r1_d;
    logic              byp0, byp1, hit0, hit1;

    // Not-ready operands hold the producer tag in their low bits.
    assign byp0 = cdb_valid_i && (cdb_tag_i == src0_i[TAG_W-1:0]);
    assign byp1 = cdb_valid_i && (cdb_tag_i == src1_i[TAG_W-1:0]);
    assign hit0 = cdb_valid_i && (cdb_tag_i == v0_q[TAG_W-1:0]);
    assign hit1 = cdb_valid_i && (cdb_tag_i == v1_q[TAG_W-1:0]);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        unique case (state_q)
            RS_FREE: begin
                if (alloc_i) begin
                    op_d    = op_i;
                    r0_d    = rdy0_i || byp0;
                    r1_d    = rdy1_i || byp1;
                    v0_d    = (!rdy0_i && byp0) ? cdb_data_i : src0_i;
                    v1_d    = (!rdy1_i && byp1) ? cdb_data_i : src1_i;
                    state_d = (r0_d && r1_d) ? RS_READY : RS_WAITING;
                end
            end
            RS_WAITING: begin
                if (!r0_q && hit0) begin
                    r0_d = 1'b1;
                    v0_d = cdb_data_i;
                end
                if (!r1_q && hit1) begin
                    r1_d = 1'b1;
                    v1_d = cdb_data_i;
                end
                if (r0_d && r1_d) state_d = RS_READY;
            end
            RS_READY: begin
                if (dispatch_i) state_d = RS_EXEC;
            end
            RS_EXEC: begin
                if (cdb_valid_i && cdb_tag_i == TAG) state_d = RS_FREE;
            end
            default: state_d = RS_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RS_FREE;
            op_q    <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            r0_q    <= 1'b0;
            r1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
        end
    end

    assign free_o  = (state_q == RS_FREE);
    assign ready_o = (state_q == RS_READY);
    assign op_o    = op_q;
    assign val0_o  = v0_q;
    assign val1_o  = v1_q;

endmodule

// File: rtl/fxu_rs.sv
// Reservation-station array for the fixed-point unit: lowest-free issue
// allocation and lowest-ready dispatch on an every-other-cycle cadence.
module fxu_rs
    import tomasulo_pkg::*;
#(
    parameter int               N       = 4,
    parameter logic [TAG_W-1:0] RS_BASE = 6'h08
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [3:0]        issue_op,
    input  logic              issue_rdy0,
    input  logic              issue_rdy1,
    input  logic [DATA_W-1:0] issue_src0,
    input  logic [DATA_W-1:0] issue_src1,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_rs_num,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_rs_num,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              fu_valid,
    output logic [TAG_W-1:0]  fu_rs_num,
    output logic [3:0]        fu_op,
    output logic [DATA_W-1:0] fu_val0,
    output logic [DATA_W-1:0] fu_val1
);

    logic [N-1:0]      free_v, ready_v, alloc_oh, disp_oh;
    logic [3:0]        ent_op [N];
    logic [DATA_W-1:0] ent_v0 [N];
    logic [DATA_W-1:0] ent_v1 [N];

    logic [2:0]        alloc_idx, sel_idx;
    logic [3:0]        sel_op;
    logic [DATA_W-1:0] sel_v0, sel_v1;
    logic              issue_acc, disp_en;

    logic              fu_valid_q, fu_valid_d;
    logic [TAG_W-1:0]  fu_tag_q, fu_tag_d;
    logic [3:0]        fu_op_q, fu_op_d;
    logic [DATA_W-1:0] fu_v0_q, fu_v0_d, fu_v1_q, fu_v1_d;

    for (genvar i = 0; i < N; i++) begin : g_ent
        fxu_rs_entry #(.TAG(RS_BASE + TAG_W'(i))) u_ent (
            .clk         (clk),
            .reset       (reset),
            .alloc_i     (issue_acc && alloc_oh[i]),
            .op_i        (issue_op),
            .rdy0_i      (issue_rdy0),
            .rdy1_i      (issue_rdy1),
            .src0_i      (issue_src0),
            .src1_i      (issue_src1),
            .dispatch_i  (disp_en && disp_oh[i]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_rs_num),
            .cdb_data_i  (cdb_data),
            .free_o      (free_v[i]),
            .ready_o     (ready_v[i]),
            .op_o        (ent_op[i]),
            .val0_o      (ent_v0[i]),
            .val1_o      (ent_v1[i])
        );
    end

    // Scanning downward lets the lowest index win both encoders.
    always_comb begin
        alloc_idx = '0;
        alloc_oh  = '0;
        sel_idx   = '0;
        disp_oh   = '0;
        sel_op    = '0;
        sel_v0    = '0;
        sel_v1    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_v[i]) begin
                alloc_idx   = 3'(i);
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
            if (ready_v[i]) begin
                sel_idx    = 3'(i);
                disp_oh    = '0;
                disp_oh[i] = 1'b1;
                sel_op     = ent_op[i];
                sel_v0     = ent_v0[i];
                sel_v1     = ent_v1[i];
            end
        end
    end

    assign issue_ready  = |free_v;
    assign issue_rs_num = RS_BASE + {3'b000, alloc_idx};
    assign issue_acc    = issue_valid && issue_ready;
    assign disp_en      = !fu_valid_q && |ready_v;

    always_comb begin
        fu_valid_d = disp_en;
        fu_tag_d   = fu_tag_q;
        fu_op_d    = fu_op_q;
        fu_v0_d    = fu_v0_q;
        fu_v1_d    = fu_v1_q;
        if (disp_en) begin
            fu_tag_d = RS_BASE + {3'b000, sel_idx};
            fu_op_d  = sel_op;
            fu_v0_d  = sel_v0;
            fu_v1_d  = sel_v1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fu_valid_q <= 1'b0;
            fu_tag_q   <= '0;
            fu_op_q    <= '0;
            fu_v0_q    <= '0;
            fu_v1_q    <= '0;
        end else begin
            fu_valid_q <= fu_valid_d;
            fu_tag_q   <= fu_tag_d;
            fu_op_q    <= fu_op_d;
            fu_v0_q    <= fu_v0_d;
            fu_v1_q    <= fu_v1_d;
        end
    end

    assign fu_valid  = fu_valid_q;
    assign fu_rs_num = fu_tag_q;
    assign fu_op     = fu_op_q;
    assign fu_val0   = fu_v0_q;
    assign fu_val1   = fu_v1_q;

endmodule

// File: tb/tb_fxu_rs.sv
// Scoreboard bench for fxu_rs: directed issues push expected dispatches,
// a negedge monitor pops and compares every fu_valid pulse.
module tb_fxu_rs;

    typedef struct packed {
        logic [5:0]  tag;
        logic [3:0]  op;
        logic [15:0] v0;
        logic [15:0] v1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_op = '0;
    logic        issue_rdy0 = 1'b0, issue_rdy1 = 1'b0;
    logic [15:0] issue_src0 = '0, issue_src1 = '0;
    logic        issue_ready;
    logic [5:0]  issue_rs_num;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_rs_num = '0;
    logic [15:0] cdb_data = '0;
    logic        fu_valid;
    logic [5:0]  fu_rs_num;
    logic [3:0]  fu_op;
    logic [15:0] fu_val0, fu_val1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    fxu_rs #(.N(4), .RS_BASE(6'h08)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_rdy0   (issue_rdy0),
        .issue_rdy1   (issue_rdy1),
        .issue_src0   (issue_src0),
        .issue_src1   (issue_src1),
        .issue_ready  (issue_ready),
        .issue_rs_num (issue_rs_num),
        .cdb_valid    (cdb_valid),
        .cdb_rs_num   (cdb_rs_num),
        .cdb_data     (cdb_data),
        .fu_valid     (fu_valid),
        .fu_rs_num    (fu_rs_num),
        .fu_op        (fu_op),
        .fu_val0      (fu_val0),
        .fu_val1      (fu_val1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_set(input logic [3:0] op, input logic r0, input logic [15:0] s0,
                             input logic r1, input logic [15:0] s1);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rdy0  = r0;
        issue_src0  = s0;
        issue_rdy1  = r1;
        issue_src1  = s1;
    endtask

    task automatic issue_clr();
        issue_valid = 1'b0;
    endtask

    task automatic cdb_set(input logic [5:0] tag, input logic [15:0] data);
        cdb_valid  = 1'b1;
        cdb_rs_num = tag;
        cdb_data   = data;
    endtask

    task automatic cdb_pulse(input logic [5:0] tag, input logic [15:0] data);
        cdb_set(tag, data);
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic push(input logic [5:0] tag, input logic [3:0] op,
                        input logic [15:0] v0, input logic [15:0] v1);
        exp_t e;
        e.tag = tag;
        e.op  = op;
        e.v0  = v0;
        e.v1  = v1;
        sb.push_back(e);
    endtask

    // Monitor: every dispatch pulse must match the head of the scoreboard.
    initial begin : monitor
        logic prev;
        exp_t e;
        exp_t got;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fu_valid) begin
                chk("fu_valid_back_to_back", {63'd0, prev}, 64'd0);
                got = {fu_rs_num, fu_op, fu_val0, fu_val1};
                if (sb.size() == 0) begin
                    chk("unexpected_dispatch", {22'd0, got}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("dispatch", {22'd0, got}, {22'd0, e});
                end
            end
            prev = fu_valid;
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        step();
        step();
        reset = 1'b0;
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_issue_rs_num", 64'(issue_rs_num), 64'h08);
        chk("rst_fu_valid", 64'(fu_valid), 64'd0);
        chk("rst_fu_rs_num", 64'(fu_rs_num), 64'd0);
        chk("rst_fu_op", 64'(fu_op), 64'd0);
        chk("rst_fu_vals", {32'd0, fu_val0, fu_val1}, 64'd0);

        // ADD, both operands ready
        issue_set(4'd1, 1'b1, 16'd5, 1'b1, 16'd7);
        chk("t1_rs_num", 64'(issue_rs_num), 64'h08);
        push(6'h08, 4'd1, 16'd5, 16'd7);
        step();
        issue_clr();
        chk("t1_no_early_valid", 64'(fu_valid), 64'd0);
        step();
        chk("t1_fu_valid", 64'(fu_valid), 64'd1);
        chk("t1_rs_num_busy", 64'(issue_rs_num), 64'h09);
        step();
        cdb_pulse(6'h08, 16'd12);
        chk("t1_freed", 64'(issue_rs_num), 64'h08);

        // JEQ waiting on tag 9
        issue_set(4'd6, 1'b0, 16'h0009, 1'b1, 16'd3);
        push(6'h08, 4'd6, 16'd3, 16'd3);
        step();
        issue_clr();
        step();
        chk("t2_waiting", 64'(fu_valid), 64'd0);
        cdb_pulse(6'h09, 16'd3);
        chk("t2_not_yet", 64'(fu_valid), 64'd0);
        step();
        chk("t2_dispatch", 64'(fu_valid), 64'd1);
        step();
        cdb_pulse(6'h08, 16'd0);

        // issue-cycle bypass of tag 12
        issue_set(4'd1, 1'b0, 16'h000C, 1'b1, 16'h0001);
        cdb_set(6'h0C, 16'hBEEF);
        push(6'h08, 4'd1, 16'hBEEF, 16'h0001);
        step();
        issue_clr();
        cdb_valid = 1'b0;
        step();
        chk("t3_dispatch", 64'(fu_valid), 64'd1);
        step();
        cdb_pulse(6'h08, 16'd0);

        // fill all four entries
        for (int i = 0; i < 4; i++) begin
            issue_set(4'd1, 1'b1, 16'(2 * i + 1), 1'b1, 16'(2 * i + 2));
            push(6'(8 + i), 4'd1, 16'(2 * i + 1), 16'(2 * i + 2));
            step();
        end
        chk("t4_full", 64'(issue_ready), 64'd0);
        issue_set(4'd1, 1'b1, 16'd99, 1'b1, 16'd99);
        step();
        step();
        chk("t4_still_full", 64'(issue_ready), 64'd0);
        issue_clr();
        repeat (8) step();
        chk("t4_all_exec", 64'(issue_ready), 64'd0);
        cdb_pulse(6'h0A, 16'd0);
        chk("t4_ready_back", 64'(issue_ready), 64'd1);
        chk("t4_rs_num_10", 64'(issue_rs_num), 64'h0A);
        cdb_pulse(6'h08, 16'd0);
        cdb_pulse(6'h09, 16'd0);
        cdb_pulse(6'h0B, 16'd0);
        chk("t4_all_free", 64'(issue_rs_num), 64'h08);

        // two entries become READY on one broadcast
        issue_set(4'd1, 1'b0, 16'd20, 1'b1, 16'h0011);
        push(6'h08, 4'd1, 16'h0055, 16'h0011);
        step();
        issue_set(4'd6, 1'b0, 16'd20, 1'b0, 16'd20);
        push(6'h09, 4'd6, 16'h0055, 16'h0055);
        step();
        issue_clr();
        step();
        chk("t5_waiting", 64'(fu_valid), 64'd0);
        cdb_pulse(6'd20, 16'h0055);
        step();
        chk("t5_first", 64'(fu_rs_num), 64'h08);
        step();
        chk("t5_gap", 64'(fu_valid), 64'd0);
        step();
        chk("t5_second", 64'(fu_rs_num), 64'h09);
        cdb_pulse(6'h08, 16'd0);
        cdb_pulse(6'h09, 16'd0);

        // reset with occupied entries, one in EXEC
        issue_set(4'd1, 1'b1, 16'h000A, 1'b1, 16'h000B);
        push(6'h08, 4'd1, 16'h000A, 16'h000B);
        step();
        issue_set(4'd1, 1'b0, 16'd30, 1'b1, 16'd1);
        step();
        issue_set(4'd1, 1'b0, 16'd31, 1'b1, 16'd2);
        step();
        issue_clr();
        chk("t6_occupied", 64'(issue_rs_num), 64'h0B);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cdb_pulse(6'h08, 16'h1111);
        cdb_pulse(6'd30, 16'h2222);
        cdb_pulse(6'd31, 16'h3333);
        chk("t6_issue_ready", 64'(issue_ready), 64'd1);
        chk("t6_rs_num", 64'(issue_rs_num), 64'h08);
        chk("t6_fu_valid", 64'(fu_valid), 64'd0);
        chk("t6_fu_regs", {fu_rs_num, fu_op, fu_val0, fu_val1}, 64'd0);
        repeat (4) step();

        issue_set(4'd1, 1'b1, 16'h1234, 1'b1, 16'h4321);
        push(6'h08, 4'd1, 16'h1234, 16'h4321);
        step();
        issue_clr();
        step();
        chk("t6_post_dispatch", 64'(fu_valid), 64'd1);
        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
